// File: rtl/motor_arb_pkg.sv
// Shared definitions for the motor arbiter: command codes, requester
// indices, wheel-direction encoding and the command decode helpers.
package motor_arb_pkg;

    localparam logic [2:0] CMD_STOP   = 3'd0;
    localparam logic [2:0] CMD_FWD    = 3'd1;
    localparam logic [2:0] CMD_BACK   = 3'd2;
    localparam logic [2:0] CMD_LEFT   = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_SPIN_L = 3'd5;
    localparam logic [2:0] CMD_SPIN_R = 3'd6;

    localparam int REQ_OBST   = 0;
    localparam int REQ_REMOTE = 1;
    localparam int REQ_LINE   = 2;
    localparam int REQ_CYCLE  = 3;
    localparam int NUM_REQ    = 4;

    // Encoding matches the H-bridge pin pair {x1,x2}: fwd=10, back=01.
    typedef enum logic [1:0] {
        WD_OFF  = 2'b00,
        WD_BACK = 2'b01,
        WD_FWD  = 2'b10
    } wheel_dir_t;

    typedef struct packed {
        wheel_dir_t l;
        wheel_dir_t r;
    } wheel_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } arb_state_t;

    function automatic wheel_pair_t decode_cmd(input logic [2:0] c);
        wheel_pair_t p;
        p.l = WD_OFF;
        p.r = WD_OFF;
        case (c)
            CMD_STOP:   ;
            CMD_FWD:    begin p.l = WD_FWD;  p.r = WD_FWD;  end
            CMD_BACK:   begin p.l = WD_BACK; p.r = WD_BACK; end
            CMD_LEFT:   begin p.l = WD_OFF;  p.r = WD_FWD;  end
            CMD_RIGHT:  begin p.l = WD_FWD;  p.r = WD_OFF;  end
            CMD_SPIN_L: begin p.l = WD_BACK; p.r = WD_FWD;  end
            CMD_SPIN_R: begin p.l = WD_FWD;  p.r = WD_BACK; end
            default:    ;
        endcase
        return p;
    endfunction

    // Only fwd<->back counts; starting from or stopping to off is harmless.
    function automatic logic is_reversal(input wheel_dir_t cur, input wheel_dir_t nxt);
        return ((cur == WD_FWD) && (nxt == WD_BACK)) || ((cur == WD_BACK) && (nxt == WD_FWD));
    endfunction

endpackage

// File: rtl/motor_pwm.sv
// PWM generator: prescaler, 8-bit period counter and two gated duty
// comparators with registered enables.
import motor_arb_pkg::*;

module motor_pwm #(
    parameter int PWM_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_gate1,
    input  logic       i_gate2,
    input  logic [7:0] i_duty,
    output logic       o_en1,
    output logic       o_en2
);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [7:0]    r_cnt;
    logic          r_en1;
    logic          r_en2;
    logic          w_wrap;

    assign w_wrap = (r_pre == PW'(PWM_DIV - 1));
    assign o_en1  = r_en1;
    assign o_en2  = r_en2;

    // Prescaler and period counter; duty is compared against the count
    // before the edge so a duty change lands on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_en1 <= 1'b0;
            r_en2 <= 1'b0;
        end else begin
            r_pre <= w_wrap ? '0 : r_pre + PW'(1);
            if (w_wrap)
                r_cnt <= r_cnt + 8'd1;
            r_en1 <= i_gate1 && (r_cnt < i_duty);
            r_en2 <= i_gate2 && (r_cnt < i_duty);
        end
    end

endmodule

// File: rtl/motor_arbiter.sv
// Motor driver arbiter: fixed-priority grant among four mode engines,
// command decode to wheel lines, dead-time on wheel reversal, PWM enables.
// Optional remote keep-alive watchdog: define MOTOR_ARB_WDOG_EN.
import motor_arb_pkg::*;

module motor_arbiter #(
    parameter int PWM_DIV  = 50,
    parameter int DEAD_CYC = 1000,
    parameter int WDOG_CYC = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN_BIZHANG,
    input  logic        EN_YAOKONG,
    input  logic        EN_XUNJI,
    input  logic        EN_CYCLE,
    input  logic [3:0]  req,
    input  logic [11:0] cmd,
    input  logic [31:0] duty,
    input  logic        rc_alive,
    output logic        zuo1,
    output logic        zuo2,
    output logic        you1,
    output logic        you2,
    output logic        en1,
    output logic        en2,
    output logic [3:0]  grant,
    output logic        dead
);
    localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    arb_state_t  r_state, w_nstate;
    wheel_dir_t  r_l, r_r, w_nl, w_nr;
    logic [DCW-1:0] r_dcnt, w_dcnt_nxt;
    logic [3:0]  r_grant, w_elig, w_win_oh, w_en_mask;
    logic [2:0]  w_cmd;
    logic [7:0]  w_duty;
    wheel_pair_t w_dec;
    logic        w_any, w_rc_ok, r_dead, w_gate1, w_gate2;

`ifdef MOTOR_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] r_wcnt;

    // Keep-alive timer: starts saturated so the remote stays locked out
    // until its first pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wcnt <= WW'(WDOG_CYC);
        else if (rc_alive)
            r_wcnt <= '0;
        else if (r_wcnt != WW'(WDOG_CYC))
            r_wcnt <= r_wcnt + WW'(1);
    end
    assign w_rc_ok = (r_wcnt != WW'(WDOG_CYC));
`else
    logic w_unused_rc;
    assign w_unused_rc = rc_alive | (WDOG_CYC < 1);
    assign w_rc_ok     = 1'b1;
`endif

    always_comb begin
        w_en_mask             = '0;
        w_en_mask[REQ_OBST]   = EN_BIZHANG;
        w_en_mask[REQ_REMOTE] = EN_YAOKONG & w_rc_ok;
        w_en_mask[REQ_LINE]   = EN_XUNJI;
        w_en_mask[REQ_CYCLE]  = EN_CYCLE;
    end

    assign w_elig = req & w_en_mask;
    assign w_any  = |w_elig;

    // Fixed priority: scanning high to low leaves the lowest index winning.
    always_comb begin
        w_win_oh = '0;
        w_cmd    = '0;
        w_duty   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_cmd       = cmd[3*i +: 3];
                w_duty      = duty[8*i +: 8];
            end
        end
    end

    assign w_dec = decode_cmd(w_cmd);

    // Next state and next wheel directions; lines default to off so
    // IDLE and DEAD never drive the bridge.
    always_comb begin
        w_nstate   = r_state;
        w_nl       = WD_OFF;
        w_nr       = WD_OFF;
        w_dcnt_nxt = r_dcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_nstate = ST_DRIVE;
                    w_nl     = w_dec.l;
                    w_nr     = w_dec.r;
                end
            end
            ST_DRIVE: begin
                if (!w_any) begin
                    w_nstate = ST_IDLE;
                end else if (is_reversal(r_l, w_dec.l) || is_reversal(r_r, w_dec.r)) begin
                    w_nstate   = ST_DEAD;
                    w_dcnt_nxt = '0;
                end else begin
                    w_nl = w_dec.l;
                    w_nr = w_dec.r;
                end
            end
            ST_DEAD: begin
                if (r_dcnt == DCW'(DEAD_CYC - 1)) begin
                    if (w_any) begin
                        w_nstate = ST_DRIVE;
                        w_nl     = w_dec.l;
                        w_nr     = w_dec.r;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + DCW'(1);
                end
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    // State, wheel lines, grant and dead flag all come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_l     <= WD_OFF;
            r_r     <= WD_OFF;
            r_dcnt  <= '0;
            r_grant <= '0;
            r_dead  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_l     <= w_nl;
            r_r     <= w_nr;
            r_dcnt  <= w_dcnt_nxt;
            r_grant <= w_win_oh;
            r_dead  <= (w_nstate == ST_DEAD);
        end
    end

    assign w_gate1 = (w_nstate == ST_DRIVE) && (w_nl != WD_OFF);
    assign w_gate2 = (w_nstate == ST_DRIVE) && (w_nr != WD_OFF);

    motor_pwm #(.PWM_DIV(PWM_DIV)) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_gate1 (w_gate1),
        .i_gate2 (w_gate2),
        .i_duty  (w_duty),
        .o_en1   (en1),
        .o_en2   (en2)
    );

    assign {zuo1, zuo2} = r_l;
    assign {you1, you2} = r_r;
    assign grant        = r_grant;
    assign dead         = r_dead;

endmodule

// File: tb/tb_motor_arbiter.sv
// Bench for motor_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_motor_arbiter;
    localparam int PWM_DIV  = 1;
    localparam int DEAD_CYC = 5;
    localparam int WDOG_CYC = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EN_BIZHANG, EN_YAOKONG, EN_XUNJI, EN_CYCLE;
    logic [3:0]  req;
    logic [11:0] cmd;
    logic [31:0] duty;
    logic        rc_alive;
    logic        zuo1, zuo2, you1, you2, en1, en2, dead;
    logic [3:0]  grant;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    motor_arbiter #(.PWM_DIV(PWM_DIV), .DEAD_CYC(DEAD_CYC), .WDOG_CYC(WDOG_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .EN_BIZHANG(EN_BIZHANG), .EN_YAOKONG(EN_YAOKONG), .EN_XUNJI(EN_XUNJI), .EN_CYCLE(EN_CYCLE),
        .req(req), .cmd(cmd), .duty(duty), .rc_alive(rc_alive),
        .zuo1(zuo1), .zuo2(zuo2), .you1(you1), .you2(you2),
        .en1(en1), .en2(en2), .grant(grant), .dead(dead)
    );

    // Wheel motion per command as signed direction: +1 fwd, -1 back, 0 off.
    int dec_l [8] = '{0, 1, -1, 0, 1, -1,  1, 0};
    int dec_r [8] = '{0, 1, -1, 1, 0,  1, -1, 0};

    // Model: mode 0 idle, 1 driving, 2 dead time.
    int m_mode, m_l, m_r, m_left, m_pwm, m_pre, m_wd, m_win, m_nl, m_nr, m_c, m_duty;
    logic [3:0] m_grant, m_elig;
    logic m_en1, m_en2, m_rc_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_l = 0; m_r = 0; m_left = 0;
            m_pwm = 0; m_pre = 0; m_wd = WDOG_CYC;
            m_grant = 4'b0; m_en1 = 1'b0; m_en2 = 1'b0;
        end else begin
            m_rc_ok = 1'b1;
`ifdef MOTOR_ARB_WDOG_EN
            m_rc_ok = (m_wd < WDOG_CYC);
            if (rc_alive) m_wd = 0;
            else if (m_wd < WDOG_CYC) m_wd = m_wd + 1;
`endif
            m_elig = req & {EN_CYCLE, EN_XUNJI, EN_YAOKONG & m_rc_ok, EN_BIZHANG};
            m_win = -1;
            for (int i = 3; i >= 0; i--) if (m_elig[i]) m_win = i;
            m_nl = 0; m_nr = 0; m_duty = 0;
            if (m_win >= 0) begin
                m_c    = int'(cmd[3*m_win +: 3]);
                m_nl   = dec_l[m_c];
                m_nr   = dec_r[m_c];
                m_duty = int'(duty[8*m_win +: 8]);
            end
            m_grant = (m_win >= 0) ? 4'(1 << m_win) : 4'b0;
            case (m_mode)
                0: if (m_win >= 0) begin m_mode = 1; m_l = m_nl; m_r = m_nr; end
                1: begin
                    if (m_win < 0) begin
                        m_mode = 0; m_l = 0; m_r = 0;
                    end else if (m_nl * m_l < 0 || m_nr * m_r < 0) begin
                        m_mode = 2; m_left = DEAD_CYC; m_l = 0; m_r = 0;
                    end else begin
                        m_l = m_nl; m_r = m_nr;
                    end
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_win >= 0) begin m_mode = 1; m_l = m_nl; m_r = m_nr; end
                        else m_mode = 0;
                    end
                end
            endcase
            m_en1 = (m_mode == 1) && (m_l != 0) && (m_pwm < m_duty);
            m_en2 = (m_mode == 1) && (m_r != 0) && (m_pwm < m_duty);
            if (m_pre == PWM_DIV - 1) begin m_pre = 0; m_pwm = (m_pwm + 1) % 256; end
            else m_pre = m_pre + 1;
        end
    end

    function automatic logic [3:0] lines();
        return {zuo1, zuo2, you1, you2};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_loop();
        logic [10:0] got, exp;
        forever begin
            @(negedge clk);
            if (rst_n && chk_on) begin
                got = {grant, zuo1, zuo2, you1, you2, en1, en2, dead};
                exp = {m_grant, m_l == 1, m_l == -1, m_r == 1, m_r == -1, m_en1, m_en2, m_mode == 2};
                check("model_outputs", {21'b0, got}, {21'b0, exp});
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int hi1, hi2;

    initial begin
        rst_n = 1'b0; req = '0; cmd = '0; duty = '0; rc_alive = 1'b0;
        {EN_BIZHANG, EN_YAOKONG, EN_XUNJI, EN_CYCLE} = 4'b0;
        fork compare_loop(); join_none
        cyc(3);
        check("reset_out", {grant, lines(), en1, en2, dead}, 0);
        rst_n = 1'b1; chk_on = 1'b1;
        cyc(2);
        check("idle_out", {grant, lines(), en1, en2, dead}, 0);

        // Line follow FWD at half duty.
        req = 4'b0100; EN_XUNJI = 1'b1; cmd[8:6] = 3'd1; duty[23:16] = 8'd128;
        cyc(1);
        check("t1_grant", grant, 4'b0100);
        check("t1_lines", lines(), 4'b1010);
        hi1 = 0; hi2 = 0;
        repeat (256) begin cyc(1); hi1 += int'(en1); hi2 += int'(en2); end
        check("t1_en1_cnt", hi1, 128);
        check("t1_en2_cnt", hi2, 128);

        // Obstacle preempts with BACK: reversal goes through dead time.
        req[0] = 1'b1; EN_BIZHANG = 1'b1; cmd[2:0] = 3'd2; duty[7:0] = 8'd200;
        for (int k = 0; k < DEAD_CYC; k++) begin
            cyc(1);
            check("t2_dead", {dead, lines(), grant}, {1'b1, 4'b0000, 4'b0001});
        end
        cyc(1);
        check("t2_after", {dead, lines(), grant}, {1'b0, 4'b0101, 4'b0001});

        // Back to FWD via STOP, then LEFT preempt without dead time.
        cmd[2:0] = 3'd0; cyc(1);
        check("t3_stop", {dead, lines()}, {1'b0, 4'b0000});
        req[0] = 1'b0; cyc(1);
        check("t3_fwd", {grant, lines()}, {4'b0100, 4'b1010});
        req[0] = 1'b1; cmd[2:0] = 3'd3; cyc(1);
        check("t3_left", {dead, lines(), en1, grant}, {1'b0, 4'b0010, 1'b0, 4'b0001});

        // All requesting, none enabled; then cycle alone.
        req = 4'b1111; {EN_BIZHANG, EN_YAOKONG, EN_XUNJI, EN_CYCLE} = 4'b0; cyc(1);
        check("t4_idle", {grant, lines(), en1, en2, dead}, 0);
        EN_CYCLE = 1'b1; cmd[11:9] = 3'd4; duty[31:24] = 8'd255; cyc(1);
        check("t4_cycle", {grant, lines()}, {4'b1000, 4'b1000});

        // Reset in the middle of dead time.
        cmd[11:9] = 3'd5; cyc(2);
        check("t5_in_dead", {dead, lines()}, {1'b1, 4'b0000});
        rst_n = 1'b0; #1;
        check("t5_async_rst", {grant, lines(), en1, en2, dead}, 0);
        cyc(2);
        rst_n = 1'b1; cyc(1);
        check("t5_post_rst", {dead, grant, lines()}, {1'b0, 4'b1000, 4'b0110});

`ifdef MOTOR_ARB_WDOG_EN
        // Remote locked until its first keep-alive, then times out.
        req = 4'b0010; EN_YAOKONG = 1'b1; EN_CYCLE = 1'b0; cmd[5:3] = 3'd1; cyc(1);
        check("t6_locked", grant, 4'b0000);
        rc_alive = 1'b1; cyc(1); rc_alive = 1'b0;
        cyc(100);
        check("t6_alive", grant, 4'b0010);
        cyc(1);
        check("t6_timeout", grant, 4'b0000);
`endif

        // Randomized traffic; inputs held for a few cycles between changes.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                req  = 4'($urandom);
                {EN_BIZHANG, EN_YAOKONG, EN_XUNJI, EN_CYCLE} = 4'($urandom | $urandom);
                cmd  = 12'($urandom);
                duty = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                cmd = 12'($urandom);
            end
            rc_alive = ($urandom_range(0, 40) == 0);
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
